// File: rtl/infra_pkg.sv
// Shared types and constants for the IR scan controller.
// The AMB state is reachable only when INFRA_AMBIENT_EN is defined.
package infra_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      AMB    = 3'd1,
      SETTLE = 3'd2,
      SAMPLE = 3'd3,
      GAP    = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam int DEF_N_CH       = 4;
   localparam int DEF_SETTLE_CYC = 500;
   localparam int DEF_SAMPLE_CYC = 64;
   localparam int DEF_GAP_CYC    = 100;
   localparam int DEF_FILT_LEN   = 5;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Width that holds 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/infra_scan_ctrl_if.sv
// Pin-side bundle of the IR scan controller; amb_fault exists only with
// INFRA_AMBIENT_EN. Levels only, no handshake: hit is valid whenever hit_vld pulses.
interface infra_scan_ctrl_if #(parameter int N_CH = 4);

   logic                  scan_en;
   logic [N_CH-1:0]       rx_in;
   logic [N_CH-1:0]       ir_tx;
   logic [N_CH-1:0]       hit;
   logic                  hit_vld;
   logic                  busy;
   infra_pkg::state_t     dbg_state;
`ifdef INFRA_AMBIENT_EN
   logic [N_CH-1:0]       amb_fault;
`endif

   modport slave (
      input  scan_en, rx_in,
      output ir_tx, hit, hit_vld, busy, dbg_state
`ifdef INFRA_AMBIENT_EN
      , output amb_fault
`endif
   );

   modport master (
      output scan_en, rx_in,
      input  ir_tx, hit, hit_vld, busy, dbg_state
`ifdef INFRA_AMBIENT_EN
      , input amb_fault
`endif
   );

endinterface

// File: rtl/infra_glitch_filt.sv
// Single-bit stability filter: output follows the input only after more than
// FILT_LEN consecutive equal compares; i_clr zeroes output and history.
module infra_glitch_filt #(
   parameter int FILT_LEN = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_din,
   output logic o_dout
);

   localparam int CW = $clog2(FILT_LEN + 2);
   localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN + 1);

   logic          r_prev;
   logic [CW-1:0] r_cnt;
   logic          r_out;
   logic [CW-1:0] w_cnt_nxt;

   // Saturating at FILT_LEN+1 keeps "more than FILT_LEN" a plain equality test.
   always_comb begin
      w_cnt_nxt = '0;
      if (i_din == r_prev) begin
         w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev <= 1'b0;
         r_cnt  <= '0;
         r_out  <= 1'b0;
      end else if (i_clr) begin
         r_prev <= 1'b0;
         r_cnt  <= '0;
         r_out  <= 1'b0;
      end else begin
         r_prev <= i_din;
         r_cnt  <= w_cnt_nxt;
         if (w_cnt_nxt == CNT_MAX) begin
            r_out <= i_din;
         end
      end
   end

   assign o_dout = r_out;

endmodule

// File: rtl/infra_scan_ctrl.sv
// Time-multiplexed IR emitter/receiver scanner with one shared glitch filter.
// Define INFRA_AMBIENT_EN to add a dark (AMB) measurement before each channel.
module infra_scan_ctrl
   import infra_pkg::*;
#(
   parameter int N_CH       = DEF_N_CH,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
   parameter int GAP_CYC    = DEF_GAP_CYC,
   parameter int FILT_LEN   = DEF_FILT_LEN
) (
   input logic                clk,
   input logic                rst_n,
   infra_scan_ctrl_if.slave   bus
);

   localparam int CW  = cnt_width(max3(SETTLE_CYC, SAMPLE_CYC, GAP_CYC));
   localparam int CHW = cnt_width(N_CH);

   localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0]  SAMPLE_LAST = CW'(SAMPLE_CYC - 1);
   localparam logic [CW-1:0]  GAP_LAST    = CW'(GAP_CYC - 1);
   localparam logic [CHW-1:0] CH_LAST     = CHW'(N_CH - 1);

`ifdef INFRA_AMBIENT_EN
   localparam state_t CH_ENTRY = AMB;
`else
   localparam state_t CH_ENTRY = SETTLE;
`endif

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CHW-1:0]  r_ch;
   logic [CHW-1:0]  w_ch_nxt;
   logic [N_CH-1:0] r_on;
   logic [N_CH-1:0] r_hit;
   logic [N_CH-1:0] w_tx;
   logic [N_CH-1:0] w_hit_nxt;
   logic            w_phase_end;
   logic            w_state_chg;
   logic            w_filt_clr;
   logic            w_filt_in;
   logic            w_filt_out;
`ifdef INFRA_AMBIENT_EN
   logic [N_CH-1:0] r_amb;
   logic [N_CH-1:0] r_amb_fault;
`endif

   always_comb begin
      w_phase_end = 1'b0;
      case (r_state)
`ifdef INFRA_AMBIENT_EN
         AMB:     w_phase_end = (r_cnt == SAMPLE_LAST);
`endif
         SETTLE:  w_phase_end = (r_cnt == SETTLE_LAST);
         SAMPLE:  w_phase_end = (r_cnt == SAMPLE_LAST);
         GAP:     w_phase_end = (r_cnt == GAP_LAST);
         default: w_phase_end = 1'b0;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ch_nxt    = r_ch;
      case (r_state)
         IDLE: begin
            if (bus.scan_en) begin
               w_state_nxt = CH_ENTRY;
               w_ch_nxt    = '0;
            end
         end
`ifdef INFRA_AMBIENT_EN
         AMB:     if (w_phase_end) w_state_nxt = SETTLE;
`endif
         SETTLE:  if (w_phase_end) w_state_nxt = SAMPLE;
         SAMPLE:  if (w_phase_end) w_state_nxt = GAP;
         GAP: begin
            if (w_phase_end) begin
               if (r_ch != CH_LAST) begin
                  w_ch_nxt    = r_ch + 1'b1;
                  w_state_nxt = CH_ENTRY;
               end else begin
                  w_state_nxt = DONE;
               end
            end
         end
         // scan_en is only consulted here, so a mid-scan drop lets the scan finish.
         DONE: begin
            if (bus.scan_en) begin
               w_state_nxt = CH_ENTRY;
               w_ch_nxt    = '0;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_state_chg = (w_state_nxt != r_state);
   assign w_filt_clr  = w_state_chg && ((w_state_nxt == SETTLE) || (w_state_nxt == AMB));
   assign w_filt_in   = bus.rx_in[r_ch];

`ifdef INFRA_AMBIENT_EN
   assign w_hit_nxt = r_on & ~r_amb;
`else
   assign w_hit_nxt = r_on;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ch    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ch    <= w_ch_nxt;
         r_cnt   <= (w_state_chg || (r_state == IDLE)) ? '0 : r_cnt + 1'b1;
      end
   end

   // hit is loaded on the edge into DONE so it changes together with hit_vld.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_on  <= '0;
         r_hit <= '0;
      end else begin
         if ((r_state == SAMPLE) && w_phase_end) begin
            r_on[r_ch] <= w_filt_out;
         end
         if ((w_state_nxt == DONE) && (r_state != DONE)) begin
            r_hit <= w_hit_nxt;
         end
      end
   end

`ifdef INFRA_AMBIENT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_amb       <= '0;
         r_amb_fault <= '0;
      end else begin
         if ((r_state == AMB) && w_phase_end) begin
            r_amb[r_ch] <= w_filt_out;
         end
         if ((w_state_nxt == DONE) && (r_state != DONE)) begin
            r_amb_fault <= r_amb;
         end
      end
   end

   assign bus.amb_fault = r_amb_fault;
`endif

   // Emitters decode straight from state so an async reset darkens them at once.
   always_comb begin
      w_tx = '0;
      if ((r_state == SETTLE) || (r_state == SAMPLE)) begin
         w_tx[r_ch] = 1'b1;
      end
   end

   infra_glitch_filt #(
      .FILT_LEN (FILT_LEN)
   ) u_filt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_filt_clr),
      .i_din  (w_filt_in),
      .o_dout (w_filt_out)
   );

   assign bus.ir_tx     = w_tx;
   assign bus.hit       = r_hit;
   assign bus.hit_vld   = (r_state == DONE);
   assign bus.busy      = (r_state != IDLE);
   assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_infra_scan_ctrl.sv
// Directed bench for infra_scan_ctrl; runs in both the default and the
// INFRA_AMBIENT_EN build with expectations chosen per build.
module tb_infra_scan_ctrl;
  import infra_pkg::*;

  localparam int N_CH   = 4;
  localparam int SETTLE = 8;
  localparam int SAMPLE = 16;
  localparam int GAP    = 4;
  localparam int FILT   = 5;
`ifdef INFRA_AMBIENT_EN
  localparam int PRE    = SAMPLE;
  localparam bit AMB_ON = 1'b1;
`else
  localparam int PRE    = 0;
  localparam bit AMB_ON = 1'b0;
`endif
  localparam int PER     = PRE + SETTLE + SAMPLE + GAP;
  localparam int VLD_CYC = 1 + N_CH * PER;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  infra_scan_ctrl_if #(.N_CH(N_CH)) bus ();

  infra_scan_ctrl #(
    .N_CH       (N_CH),
    .SETTLE_CYC (SETTLE),
    .SAMPLE_CYC (SAMPLE),
    .GAP_CYC    (GAP),
    .FILT_LEN   (FILT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [3:0] rx_base     = 4'b0000;
  bit         glitch_mode = 1'b0;
  bit         follow_mode = 1'b0;
  logic [7:0] gcnt        = 8'd0;

  always @(posedge clk) gcnt <= gcnt + 8'd1;

  // Receiver model: bit2 may carry a 1-cycle pulse every 4 cycles, bit3 may
  // see light only while its own emitter is on.
  always_comb begin
    bus.rx_in = rx_base;
    if (glitch_mode) bus.rx_in[2] = (gcnt[1:0] == 2'd0);
    if (follow_mode) bus.rx_in[3] = bus.ir_tx[3];
  end

  // Break-before-make monitor.
  int         bbm_viol = 0;
  int         n_switch = 0;
  int         low_run  = 0;
  logic [3:0] last_on  = 4'b0000;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_on <= 4'b0000;
      low_run <= 0;
    end else begin
      if (!$onehot0(bus.ir_tx)) bbm_viol <= bbm_viol + 1;
      if (bus.ir_tx == 4'b0000) begin
        low_run <= low_run + 1;
      end else begin
        low_run <= 0;
        last_on <= bus.ir_tx;
        if ((last_on != 4'b0000) && (bus.ir_tx != last_on)) begin
          n_switch <= n_switch + 1;
          if (low_run < GAP) bbm_viol <= bbm_viol + 1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    cyc = cyc + 1;
    @(negedge clk);
  endtask

  // Called at a negedge in IDLE; returns at the negedge after edge 0 (cycle 1).
  task automatic start_scan();
    bus.scan_en = 1'b1;
    cyc = 0;
    tick();
  endtask

  task automatic wait_vld(output logic [3:0] hit_before);
    hit_before = bus.hit;
    for (int i = 0; i < 1000; i++) begin
      if (bus.hit_vld) break;
      hit_before = bus.hit;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.scan_en = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.ir_tx !== 4'b0000) begin n_err++; $display("FAIL rst_ir_tx: got %b want 0000", bus.ir_tx); end
    n_cmp++; if (bus.hit !== 4'b0000) begin n_err++; $display("FAIL rst_hit: got %b want 0000", bus.hit); end
    n_cmp++; if (bus.hit_vld !== 1'b0) begin n_err++; $display("FAIL rst_hit_vld: got %b want 0", bus.hit_vld); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (bus.dbg_state !== IDLE) begin n_err++; $display("FAIL idle_state: got %0d want %0d", bus.dbg_state, IDLE); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.ir_tx !== 4'b0000) begin n_err++; $display("FAIL idle_ir_tx: got %b want 0000", bus.ir_tx); end
  endtask

  task automatic test_basic_scan();
    logic [3:0] hit_before;
    rx_base = 4'b0101;
    start_scan();
    bus.scan_en = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_c1: got %b want 1", bus.busy); end
    while (cyc < 1 + PRE) tick();
    n_cmp++; if (bus.ir_tx !== 4'b0001) begin n_err++; $display("FAIL basic_tx0_rise: got %b want 0001 at cycle %0d", bus.ir_tx, cyc); end
    wait_vld(hit_before);
    n_cmp++; if (cyc !== VLD_CYC) begin n_err++; $display("FAIL basic_vld_cycle: got %0d want %0d", cyc, VLD_CYC); end
    n_cmp++; if (hit_before !== 4'b0000) begin n_err++; $display("FAIL basic_hit_early: got %b want 0000", hit_before); end
    n_cmp++; if (bus.hit !== (AMB_ON ? 4'b0000 : 4'b0101)) begin n_err++; $display("FAIL basic_hit: got %b want %b", bus.hit, (AMB_ON ? 4'b0000 : 4'b0101)); end
`ifdef INFRA_AMBIENT_EN
    n_cmp++; if (bus.amb_fault !== 4'b0101) begin n_err++; $display("FAIL basic_amb: got %b want 0101", bus.amb_fault); end
`endif
    tick();
    n_cmp++; if (bus.hit_vld !== 1'b0) begin n_err++; $display("FAIL basic_vld_pulse: got %b want 0", bus.hit_vld); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_drop: got %b want 0 at cycle %0d", bus.busy, cyc); end
  endtask

  task automatic test_glitch();
    logic [3:0] hit_before;
    rx_base = 4'b1011;
    glitch_mode = 1'b1;
    start_scan();
    bus.scan_en = 1'b0;
    wait_vld(hit_before);
    glitch_mode = 1'b0;
    n_cmp++; if (cyc !== VLD_CYC) begin n_err++; $display("FAIL glitch_vld_cycle: got %0d want %0d", cyc, VLD_CYC); end
    n_cmp++; if (bus.hit !== (AMB_ON ? 4'b0000 : 4'b1011)) begin n_err++; $display("FAIL glitch_hit: got %b want %b", bus.hit, (AMB_ON ? 4'b0000 : 4'b1011)); end
`ifdef INFRA_AMBIENT_EN
    n_cmp++; if (bus.amb_fault !== 4'b1011) begin n_err++; $display("FAIL glitch_amb: got %b want 1011", bus.amb_fault); end
`endif
    tick();
  endtask

  task automatic test_continuous_stop();
    logic [3:0] hit_before;
    rx_base = 4'b0011;
    start_scan();
    wait_vld(hit_before);
    n_cmp++; if (bus.hit !== (AMB_ON ? 4'b0000 : 4'b0011)) begin n_err++; $display("FAIL cont_hit: got %b want %b", bus.hit, (AMB_ON ? 4'b0000 : 4'b0011)); end
    tick();
    cyc = 1;
    rx_base = 4'b0110;
    n_cmp++; if (bus.ir_tx !== (AMB_ON ? 4'b0000 : 4'b0001)) begin n_err++; $display("FAIL cont_restart_tx: got %b want %b", bus.ir_tx, (AMB_ON ? 4'b0000 : 4'b0001)); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL cont_restart_busy: got %b want 1", bus.busy); end
    while (cyc < 50) tick();
    bus.scan_en = 1'b0;
    wait_vld(hit_before);
    n_cmp++; if (cyc !== VLD_CYC) begin n_err++; $display("FAIL stop_vld_cycle: got %0d want %0d", cyc, VLD_CYC); end
    n_cmp++; if (bus.hit !== (AMB_ON ? 4'b0000 : 4'b0110)) begin n_err++; $display("FAIL stop_hit: got %b want %b", bus.hit, (AMB_ON ? 4'b0000 : 4'b0110)); end
`ifdef INFRA_AMBIENT_EN
    n_cmp++; if (bus.amb_fault !== 4'b0110) begin n_err++; $display("FAIL stop_amb: got %b want 0110", bus.amb_fault); end
`endif
    tick();
    n_cmp++; if (bus.dbg_state !== IDLE) begin n_err++; $display("FAIL stop_idle: got %0d want %0d", bus.dbg_state, IDLE); end
    n_cmp++; if (bus.ir_tx !== 4'b0000) begin n_err++; $display("FAIL stop_ir_tx: got %b want 0000", bus.ir_tx); end
  endtask

`ifdef INFRA_AMBIENT_EN
  task automatic test_ambient();
    logic [3:0] hit_before;
    rx_base = 4'b0010;
    follow_mode = 1'b1;
    start_scan();
    bus.scan_en = 1'b0;
    wait_vld(hit_before);
    follow_mode = 1'b0;
    n_cmp++; if (cyc !== 177) begin n_err++; $display("FAIL amb_vld_cycle: got %0d want 177", cyc); end
    n_cmp++; if (bus.hit !== 4'b1000) begin n_err++; $display("FAIL amb_hit: got %b want 1000", bus.hit); end
    n_cmp++; if (bus.amb_fault !== 4'b0010) begin n_err++; $display("FAIL amb_fault: got %b want 0010", bus.amb_fault); end
    tick();
  endtask
`endif

  task automatic test_bbm();
    n_cmp++; if (bbm_viol !== 0) begin n_err++; $display("FAIL bbm_violations: got %0d want 0", bbm_viol); end
    n_cmp++; if (n_switch < 3) begin n_err++; $display("FAIL bbm_switches: got %0d want >= 3", n_switch); end
  endtask

  task automatic test_reset_mid_scan();
    rx_base = 4'b1111;
    start_scan();
    while (cyc < 30) tick();
    n_cmp++; if (bus.ir_tx !== (AMB_ON ? 4'b0001 : 4'b0010)) begin n_err++; $display("FAIL mid_tx_before: got %b want %b", bus.ir_tx, (AMB_ON ? 4'b0001 : 4'b0010)); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.ir_tx !== 4'b0000) begin n_err++; $display("FAIL mid_rst_ir_tx: got %b want 0000", bus.ir_tx); end
    n_cmp++; if (bus.hit !== 4'b0000) begin n_err++; $display("FAIL mid_rst_hit: got %b want 0000", bus.hit); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
    bus.scan_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.scan_en = 1'b0;
    test_reset();
    test_basic_scan();
    test_glitch();
    test_continuous_stop();
`ifdef INFRA_AMBIENT_EN
    test_ambient();
`endif
    test_bbm();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/infra_scan_ctrl.md
# infra_scan_ctrl

Time-multiplexed scan controller for the robot's infrared emitter/receiver pairs, such as the ball-detect and kicker-zone sensors. It enables one emitter at a time and waits for optical settling. It then samples the matching receiver through a single shared glitch filter and publishes a per-channel hit vector with a valid strobe. It sits between the raw IR pins and the core-board logic that consumes ball-presence flags.

## Interface
- N_CH, 4: number of emitter/receiver pairs, 1..16.
- SETTLE_CYC, 500: cycles the emitter is on before sampling starts.
- SAMPLE_CYC, 64: sample-window length in cycles; must be > FILT_LEN+1.
- GAP_CYC, 100: all-emitters-off cycles after each channel.
- FILT_LEN, 5: filter stability threshold.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- scan_en  in  1  level; request scanning.
- rx_in  in  N_CH  raw receiver inputs; 1 = light received.
- ir_tx  out  N_CH  emitter drives; at most one bit high.
- hit  out  N_CH  latched result per channel.
- hit_vld  out  1  one-cycle pulse when hit is updated.
- busy  out  1  high in any state except IDLE.
- amb_fault  out  N_CH  present only with INFRA_AMBIENT_EN.

## Operation
- Reset values: ir_tx=0, hit=0, hit_vld=0, busy=0, amb_fault=0, state=IDLE, ch=0, all counters=0.
- Channel mux: the filter input is rx_in[ch].
- Filter behaviour:
  - The filter output takes the input value once the input has equalled its previous-cycle value for more than FILT_LEN consecutive compares.
  - Any change in the input restarts the count.
  - The filter is cleared to 0 (output and count) on every channel entry.
- States and transitions:
  - IDLE: if scan_en=1, go to SETTLE with ch=0.
  - SETTLE: ir_tx[ch]=1 for SETTLE_CYC cycles, then go to SAMPLE.
  - SAMPLE: ir_tx[ch]=1 for SAMPLE_CYC cycles. On the last cycle, latch the filter output into the on-bit for ch. Then go to GAP.
  - GAP: ir_tx=0 for GAP_CYC cycles.
    - If ch<N_CH-1: ch increments and the next state is SETTLE.
    - Otherwise the next state is DONE.
  - DONE, one cycle:
    - hit ← collected on-bits for all channels; hit_vld=1.
    - Next state is SETTLE with ch=0 if scan_en=1, else IDLE.
- Deasserting scan_en mid-scan does not abort; the current scan completes and hit_vld is issued.
- Phase counters are sized $clog2 of the largest phase, wrap-free, and cleared on every state change.
- The ch counter is $clog2(N_CH) bits wide, minimum 1 bit.
- Reset mid-scan: all emitters go off immediately (asynchronous) and hit returns to 0.

## Timing
- scan_en is seen high at edge k (in IDLE) → SETTLE is active and ir_tx[0]=1 from cycle k+1.
- Per-channel period: SETTLE_CYC+SAMPLE_CYC+GAP_CYC cycles.
- hit_vld is high in cycle k+1+N_CH·(SETTLE_CYC+SAMPLE_CYC+GAP_CYC); hit changes on the same edge.
- With continuous scan_en, ir_tx[0] rises one cycle after hit_vld.
- Break-before-make between channels: two different ir_tx bits are never high in the same cycle, and the two active periods are at least GAP_CYC cycles apart.

## Configuration
- Macro: INFRA_AMBIENT_EN. With it defined, ambient-light compensation is added:
  - An AMB state of SAMPLE_CYC cycles with ir_tx=0 precedes SETTLE for every channel. The filter is cleared on AMB entry and again on SETTLE entry.
  - The filter output on the last AMB cycle is latched as the amb-bit.
  - hit[ch] = on-bit & ~amb-bit; amb_fault[ch] = amb-bit, updated together with hit.
  - The per-channel period grows by SAMPLE_CYC.
- Without it: no AMB state, no amb_fault port, and hit[ch] = on-bit.

## Structure
- Shared package infra_pkg holds:
  - the state enum (IDLE, AMB, SETTLE, SAMPLE, GAP, DONE);
  - default timing constants;
  - the function computing counter widths.
- Sub-module infra_glitch_filt: single-bit stability filter with a sync clear input and parameter FILT_LEN. Exactly one instance, shared by all channels through the mux.

## Test plan
Bench parameters: N_CH=4, SETTLE_CYC=8, SAMPLE_CYC=16, GAP_CYC=4, FILT_LEN=5.
- Reset: rst_n=0 → ir_tx=0, hit=0, hit_vld=0, busy=0. Releasing rst_n with scan_en=0 → stays IDLE.
- Basic scan: rx_in=4'b0101 held, scan_en pulsed at edge 0 → ir_tx[0] rises in cycle 1; hit_vld in cycle 113; hit=4'b0101; busy drops in cycle 114.
- Glitch rejection: during ch2 SAMPLE, rx_in[2] is 0 with a 1-cycle high pulse every 4 cycles → hit[2]=0.
- Continuous scan and mid-scan stop:
  - Continuous scan_en → ir_tx[0] rises one cycle after hit_vld.
  - scan_en dropped at cycle 50 → the scan completes, hit_vld appears in cycle 113, then IDLE.
- Break-before-make: an assertion over the full scan checks onehot0(ir_tx) and at least 4 low cycles between channels.
- INFRA_AMBIENT_EN: rx_in[1]=1 constant (ambient light), rx_in[3] high only while ir_tx[3]=1 → hit=4'b1000, amb_fault=4'b0010; hit_vld in cycle 177.
